// File: rtl/fifo_display_buffer.sv
// Synchronous FIFO of WIDTH-bit samples feeding the hex display stage.
// dataOut holds the most recently popped word; flags and occupancy drive LEDs and control.
module fifo_display_buffer #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] dataIn,
    input  logic             clr_err,
    output logic [WIDTH-1:0] dataOut,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // A pop in the same cycle frees the slot a full FIFO is about to be written into.
    assign push_ok = wr_en && (!full || rd_en);
    assign pop_ok  = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= dataIn;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            dataOut <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                dataOut <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // A new error in the same cycle as clr_err takes priority over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full && !rd_en) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_display_buffer.sv
// Self-checking bench for fifo_display_buffer: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_fifo_display_buffer;

    localparam int WIDTH = 15;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_en = 1'b0;
    logic             rd_en = 1'b0;
    logic [WIDTH-1:0] dataIn = '0;
    logic             clr_err = 1'b0;
    logic [WIDTH-1:0] dataOut;
    logic             full;
    logic             empty;
    logic [AW:0]      count;
    logic             overflow;
    logic             underflow;

    int checks = 0;
    int fails  = 0;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_data = '0;
    logic             exp_ovf  = 1'b0;
    logic             exp_udf  = 1'b0;

    fifo_display_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en),
        .dataIn(dataIn), .clr_err(clr_err), .dataOut(dataOut),
        .full(full), .empty(empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        q.delete();
        exp_data = '0;
        exp_ovf  = 1'b0;
        exp_udf  = 1'b0;
    endtask

    // Drives one clock of stimulus and advances the reference model; returns #1 after the edge.
    task automatic drive_cycle(input logic w, input logic r, input logic [WIDTH-1:0] d, input logic c);
        int sz;
        wr_en = w; rd_en = r; dataIn = d; clr_err = c;
        sz = q.size();
        @(posedge clk);
        if (w && sz == DEPTH && !r) exp_ovf = 1'b1;
        else if (c) exp_ovf = 1'b0;
        if (r && sz == 0) exp_udf = 1'b1;
        else if (c) exp_udf = 1'b0;
        if (r && sz > 0) exp_data = q.pop_front();
        if (w && (sz < DEPTH || r)) q.push_back(d);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_flags: count=%0d empty=%b full=%b, want 0 1 0", count, empty, full); end
        checks++; if (dataOut !== 15'h0000 || overflow !== 1'b0 || underflow !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_out: dataOut=%h ovf=%b udf=%b, want 0000 0 0", dataOut, overflow, underflow); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b0, 15'(16'h0100 + i), 1'b0);
        drive_cycle(1'b0, 1'b1, '0, 1'b0);
        checks++; if (dataOut !== 15'h0100 || count !== 4'd3) begin
            fails++; $display("[TB] FAIL pre_reset: dataOut=%h count=%0d, want 0100 3", dataOut, count); end
        #3; rst_n = 1'b0; model_reset(); #1;
        checks++; if (count !== 4'd0 || empty !== 1'b1 || dataOut !== 15'h0000) begin
            fails++; $display("[TB] FAIL mid_reset: count=%0d empty=%b dataOut=%h, want 0 1 0000", count, empty, dataOut); end
        @(negedge clk); rst_n = 1'b1;
        drive_cycle(1'b0, 1'b1, '0, 1'b0);
        checks++; if (underflow !== 1'b1 || dataOut !== 15'h0000) begin
            fails++; $display("[TB] FAIL post_reset_pop: udf=%b dataOut=%h, want 1 0000", underflow, dataOut); end
    endtask

    task automatic test_order();
        logic [WIDTH-1:0] words [3];
        words[0] = 15'h1234; words[1] = 15'h0ABC; words[2] = 15'h7FFF;
        drive_cycle(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, words[i], 1'b0);
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b0; rd_en = 1'b1;
            #3;
            // Before the edge that accepts this pop, the previous word must still be showing.
            checks++; if (i > 0 && dataOut !== words[i-1]) begin
                fails++; $display("[TB] FAIL order_latency%0d: dataOut=%h, want %h", i, dataOut, words[i-1]); end
            drive_cycle(1'b0, 1'b1, '0, 1'b0);
            checks++; if (dataOut !== words[i]) begin
                fails++; $display("[TB] FAIL order%0d: dataOut=%h, want %h", i, dataOut, words[i]); end
        end
        checks++; if (empty !== 1'b1 || count !== 4'd0) begin
            fails++; $display("[TB] FAIL order_empty: empty=%b count=%0d, want 1 0", empty, count); end
    endtask

    task automatic test_full_overflow();
        for (int i = 1; i <= 8; i++) drive_cycle(1'b1, 1'b0, 15'(i), 1'b0);
        checks++; if (full !== 1'b1 || count !== 4'd8) begin
            fails++; $display("[TB] FAIL full: full=%b count=%0d, want 1 8", full, count); end
        drive_cycle(1'b1, 1'b0, 15'h0009, 1'b0);
        checks++; if (overflow !== 1'b1 || count !== 4'd8) begin
            fails++; $display("[TB] FAIL overflow: ovf=%b count=%0d, want 1 8", overflow, count); end
        drive_cycle(1'b0, 1'b0, '0, 1'b1);
        drive_cycle(1'b1, 1'b1, 15'h00AA, 1'b0);
        checks++; if (count !== 4'd8 || overflow !== 1'b0 || dataOut !== 15'h0001) begin
            fails++; $display("[TB] FAIL simul_full: count=%0d ovf=%b dataOut=%h, want 8 0 0001", count, overflow, dataOut); end
        for (int i = 0; i < 8; i++) begin
            logic [WIDTH-1:0] want;
            want = (i == 7) ? 15'h00AA : 15'(i + 2);
            drive_cycle(1'b0, 1'b1, '0, 1'b0);
            checks++; if (dataOut !== want) begin
                fails++; $display("[TB] FAIL drain%0d: dataOut=%h, want %h", i, dataOut, want); end
        end
        checks++; if (empty !== 1'b1 || underflow !== 1'b0) begin
            fails++; $display("[TB] FAIL drain_end: empty=%b udf=%b, want 1 0", empty, underflow); end
    endtask

    task automatic test_wrap_and_empty_simul();
        for (int i = 0; i < 20; i++) begin
            logic [WIDTH-1:0] w;
            w = 15'($urandom);
            drive_cycle(1'b1, 1'b0, w, 1'b0);
            drive_cycle(1'b0, 1'b1, '0, 1'b0);
            checks++; if (dataOut !== w) begin
                fails++; $display("[TB] FAIL wrap%0d: dataOut=%h, want %h", i, dataOut, w); end
        end
        begin
            logic [WIDTH-1:0] held;
            held = exp_data;
            drive_cycle(1'b1, 1'b1, 15'h0055, 1'b0);
            checks++; if (count !== 4'd1 || underflow !== 1'b1 || dataOut !== held) begin
                fails++; $display("[TB] FAIL simul_empty: count=%0d udf=%b dataOut=%h, want 1 1 %h", count, underflow, dataOut, held); end
        end
        drive_cycle(1'b0, 1'b1, '0, 1'b0);
        checks++; if (dataOut !== 15'h0055) begin
            fails++; $display("[TB] FAIL simul_empty_pop: dataOut=%h, want 0055", dataOut); end
    endtask

    task automatic test_clear_priority();
        drive_cycle(1'b0, 1'b1, '0, 1'b1);
        checks++; if (underflow !== 1'b1) begin
            fails++; $display("[TB] FAIL clr_priority: udf=%b, want 1", underflow); end
        drive_cycle(1'b0, 1'b0, '0, 1'b1);
        checks++; if (underflow !== 1'b0 || overflow !== 1'b0) begin
            fails++; $display("[TB] FAIL clr_alone: udf=%b ovf=%b, want 0 0", underflow, overflow); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            logic w, r, c;
            int phase;
            phase = (i / 60) % 3;
            w = ($urandom_range(0, 9) < (phase == 0 ? 8 : (phase == 1 ? 2 : 5)));
            r = ($urandom_range(0, 9) < (phase == 0 ? 2 : (phase == 1 ? 8 : 5)));
            c = ($urandom_range(0, 19) == 0);
            drive_cycle(w, r, 15'($urandom), c);
            checks++; if (count !== (AW+1)'(q.size()) || full !== (q.size() == DEPTH) || empty !== (q.size() == 0)) begin
                fails++; $display("[TB] FAIL rand_occ%0d: count=%0d full=%b empty=%b, want %0d", i, count, full, empty, q.size()); end
            checks++; if (dataOut !== exp_data) begin
                fails++; $display("[TB] FAIL rand_data%0d: dataOut=%h, want %h", i, dataOut, exp_data); end
            checks++; if (overflow !== exp_ovf || underflow !== exp_udf) begin
                fails++; $display("[TB] FAIL rand_flags%0d: ovf=%b udf=%b, want %b %b", i, overflow, underflow, exp_ovf, exp_udf); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_order();
        test_full_overflow();
        test_wrap_and_empty_simul();
        test_clear_priority();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
